// File: rtl/welcome_pkg.sv
// rtl/welcome_pkg.sv - shared sizes, colour type and blink states for the welcome text renderer
package welcome_pkg;

  localparam int TEXT_W = 224;
  localparam int TEXT_H = 32;

  typedef logic [11:0] rgb444_t;

  localparam rgb444_t FG_DEFAULT     = 12'hFFF;
  localparam rgb444_t BG_DEFAULT     = 12'h000;
  localparam rgb444_t BORDER_DEFAULT = 12'hF00;

  typedef enum logic [1:0] {
    S_OFF,
    S_ON,
    S_HIDE
  } blink_state_t;

endpackage

// File: rtl/welcome_blink_fsm.sv
// rtl/welcome_blink_fsm.sv - frame-synchronous show/hide/blink state machine
// WELCOME_BORDER_EN adds the active output (any state other than S_OFF).
module welcome_blink_fsm
  import welcome_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic text_en,
  input  logic blink_en,
`ifdef WELCOME_BORDER_EN
  output logic active,
`endif
  output logic visible
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

  blink_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Enables are only sampled on frame_tick so a change never tears a frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (frame_tick) begin
      case (state_q)
        S_OFF: begin
          if (text_en) begin
            state_d = S_ON;
            cnt_d   = '0;
          end
        end
        S_ON: begin
          if (!text_en) begin
            state_d = S_OFF;
            cnt_d   = '0;
          end else if (blink_en && (cnt_q == LAST)) begin
            state_d = S_HIDE;
            cnt_d   = '0;
          end else if (blink_en) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = '0;
          end
        end
        S_HIDE: begin
          if (!text_en) begin
            state_d = S_OFF;
            cnt_d   = '0;
          end else if (!blink_en || (cnt_q == LAST)) begin
            state_d = S_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign visible = (state_q == S_ON);
`ifdef WELCOME_BORDER_EN
  assign active  = (state_q != S_OFF);
`endif

endmodule

// File: rtl/welcome_text_renderer.sv
// rtl/welcome_text_renderer.sv - draws the WELCOME bitmap ROM onto the VGA pixel stream, 2-cycle latency
// Define WELCOME_BORDER_EN to draw a 2-pixel BORDER_COLOR ring around the text box.
module welcome_text_renderer
  import welcome_pkg::*;
#(
  parameter int      X0           = 208,
  parameter int      Y0           = 224,
  parameter int      SCALE_LOG2   = 0,
  parameter int      BLINK_FRAMES = 30,
  parameter rgb444_t FG_COLOR     = FG_DEFAULT,
  parameter rgb444_t BG_COLOR     = BG_DEFAULT
`ifdef WELCOME_BORDER_EN
  ,
  parameter rgb444_t BORDER_COLOR = BORDER_DEFAULT
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              frame_tick,
  input  logic              text_en,
  input  logic              blink_en,
  output logic [4:0]        drom_addr_num,
  input  logic [TEXT_W-1:0] drom_data_num,
  output logic [11:0]       rgb,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              text_pixel
);

  localparam logic [10:0] BOX_W = 11'(TEXT_W << SCALE_LOG2);
  localparam logic [10:0] BOX_H = 11'(TEXT_H << SCALE_LOG2);

  logic visible;
`ifdef WELCOME_BORDER_EN
  logic active;
`endif

  welcome_blink_fsm #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .text_en   (text_en),
    .blink_en  (blink_en),
`ifdef WELCOME_BORDER_EN
    .active    (active),
`endif
    .visible   (visible)
  );

  // Relative coordinates are 11-bit two's complement; bit 10 set means left of / above the box.
  logic [10:0] rel_x, rel_y;
  logic        in_box_d;
  logic [4:0]  row_d;
  logic [7:0]  col_d;

  assign rel_x    = {1'b0, pixel_x} - 11'(X0);
  assign rel_y    = {1'b0, pixel_y} - 11'(Y0);
  assign in_box_d = !rel_x[10] && !rel_y[10] && (rel_x < BOX_W) && (rel_y < BOX_H);
  assign row_d    = 5'(rel_y >> SCALE_LOG2);
  assign col_d    = in_box_d ? 8'(rel_x >> SCALE_LOG2) : 8'd0;

`ifdef WELCOME_BORDER_EN
  logic ext_x, ext_y, ring_d, ring_q;
  assign ext_x  = (rel_x == 11'h7FE) || (rel_x == 11'h7FF) || (!rel_x[10] && (rel_x < BOX_W + 11'd2));
  assign ext_y  = (rel_y == 11'h7FE) || (rel_y == 11'h7FF) || (!rel_y[10] && (rel_y < BOX_H + 11'd2));
  assign ring_d = ext_x && ext_y && !in_box_d;
`endif

  logic [4:0] row_q;
  logic [7:0] col_q;
  logic       in_box_q, video_on_q, hsync_q, vsync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q      <= '0;
      col_q      <= '0;
      in_box_q   <= 1'b0;
      video_on_q <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
`ifdef WELCOME_BORDER_EN
      ring_q     <= 1'b0;
`endif
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      in_box_q   <= in_box_d;
      video_on_q <= video_on;
      hsync_q    <= hsync_in;
      vsync_q    <= vsync_in;
`ifdef WELCOME_BORDER_EN
      ring_q     <= ring_d;
`endif
    end
  end

  assign drom_addr_num = row_q;

  logic    text_pixel_d;
  rgb444_t rgb_d;

  always_comb begin
    text_pixel_d = in_box_q & visible & drom_data_num[col_q];
    rgb_d        = BG_COLOR;
    if (!video_on_q) begin
      rgb_d = '0;
`ifdef WELCOME_BORDER_EN
    end else if (ring_q && active) begin
      rgb_d = BORDER_COLOR;
`endif
    end else if (text_pixel_d) begin
      rgb_d = FG_COLOR;
    end
  end

  logic [11:0] rgb_q;
  logic        text_pixel_q, hsync2_q, vsync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q        <= '0;
      text_pixel_q <= 1'b0;
      hsync2_q     <= 1'b1;
      vsync2_q     <= 1'b1;
    end else begin
      rgb_q        <= rgb_d;
      text_pixel_q <= text_pixel_d;
      hsync2_q     <= hsync_q;
      vsync2_q     <= vsync_q;
    end
  end

  assign rgb        = rgb_q;
  assign text_pixel = text_pixel_q;
  assign hsync_out  = hsync2_q;
  assign vsync_out  = vsync2_q;

endmodule

// File: tb/tb_welcome_text_renderer.sv
// tb/tb_welcome_text_renderer.sv - scoreboard bench for welcome_text_renderer (scale 1x and 2x instances)
module tb_welcome_text_renderer;

  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;
`ifdef WELCOME_BORDER_EN
  localparam logic [11:0] RING_LIVE = 12'hF00;
`else
  localparam logic [11:0] RING_LIVE = 12'h000;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [9:0]   pixel_x, pixel_y;
  logic         video_on, hsync_in, vsync_in, frame_tick, text_en, blink_en;
  logic [4:0]   addr0, addr1;
  logic [223:0] rom0, rom1;
  logic [11:0]  rgb0, rgb1;
  logic         hs0, vs0, tp0, hs1, vs1, tp1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  welcome_text_renderer #(.BLINK_FRAMES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_tick(frame_tick), .text_en(text_en),
    .blink_en(blink_en), .drom_addr_num(addr0), .drom_data_num(rom0), .rgb(rgb0),
    .hsync_out(hs0), .vsync_out(vs0), .text_pixel(tp0)
  );

  welcome_text_renderer #(.SCALE_LOG2(1), .BLINK_FRAMES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_tick(frame_tick), .text_en(text_en),
    .blink_en(blink_en), .drom_addr_num(addr1), .drom_data_num(rom1), .rgb(rgb1),
    .hsync_out(hs1), .vsync_out(vs1), .text_pixel(tp1)
  );

  // Stub ROM: row 0 lights column 1 only; row 31 lights columns 0 and 223.
  function automatic logic [223:0] rom_row(logic [4:0] a);
    logic [223:0] r;
    r = '0;
    if (a == 5'd0) r[1] = 1'b1;
    if (a == 5'd31) begin
      r[0]   = 1'b1;
      r[223] = 1'b1;
    end
    return r;
  endfunction

  assign rom0 = rom_row(addr0);
  assign rom1 = rom_row(addr1);

  task automatic check_eq(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    string       tag;
    int          due;
    int          sig;
    logic [11:0] val;
  } exp_t;

  exp_t sb[$];

  localparam int RGB0 = 0, TP0 = 1, HS0 = 2, VS0 = 3, AD0 = 4, RGB1 = 5, TP1 = 6, AD1 = 7;

  function automatic logic [11:0] actual(int s);
    case (s)
      RGB0:    return rgb0;
      TP0:     return {11'd0, tp0};
      HS0:     return {11'd0, hs0};
      VS0:     return {11'd0, vs0};
      AD0:     return {7'd0, addr0};
      RGB1:    return rgb1;
      TP1:     return {11'd0, tp1};
      default: return {7'd0, addr1};
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          check_eq(sb[i].tag, {20'd0, actual(sb[i].sig)}, {20'd0, sb[i].val});
          sb.delete(i);
        end
      end
    end
  end

  task automatic expect_at(string tag, int lat, int sig, logic [11:0] v);
    exp_t e;
    e.tag = tag;
    e.due = cyc + lat;
    e.sig = sig;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(int x, int y, logic von);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    step();
  endtask

  task automatic probe(string tag, int x, int y, logic von, int sel, logic [11:0] exp_rgb, logic exp_tp);
    expect_at({tag, "_rgb"}, 2, sel ? RGB1 : RGB0, exp_rgb);
    expect_at({tag, "_tp"}, 2, sel ? TP1 : TP0, {11'd0, exp_tp});
    pix(x, y, von);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    pix(0, 0, 1'b0);
    frame_tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pixel_x = '0; pixel_y = '0; video_on = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; frame_tick = 1'b0; text_en = 1'b0; blink_en = 1'b0;
    repeat (3) step();
    check_eq("rst_rgb", {20'd0, rgb0}, 32'd0);
    check_eq("rst_tp", {31'd0, tp0}, 32'd0);
    check_eq("rst_hs", {31'd0, hs0}, 32'd1);
    check_eq("rst_vs", {31'd0, vs0}, 32'd1);
    check_eq("rst_addr", {27'd0, addr0}, 32'd0);
    hsync_in = 1'b1; vsync_in = 1'b1;
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      hsync_in = (i != 2);
      vsync_in = (i != 3);
      expect_at($sformatf("hs_dly%0d", i), 2, HS0, {11'd0, hsync_in});
      expect_at($sformatf("vs_dly%0d", i), 2, VS0, {11'd0, vsync_in});
      pix(0, 0, 1'b0);
    end
    hsync_in = 1'b1; vsync_in = 1'b1;

    probe("off_hidden", 209, 224, 1'b1, 0, BG, 1'b0);
    probe("off_ring", 206, 224, 1'b1, 0, BG, 1'b0);

    text_en = 1'b1;
    tick();
    expect_at("bit1_addr", 1, AD0, 12'd0);
    probe("bit1", 209, 224, 1'b1, 0, FG, 1'b1);
    probe("bit0", 208, 224, 1'b1, 0, BG, 1'b0);
    probe("left_out", 207, 224, 1'b1, 0, BG, 1'b0);
    probe("right_out", 432, 224, 1'b1, 0, BG, 1'b0);
    probe("top_out", 209, 223, 1'b1, 0, BG, 1'b0);
    probe("bot_out", 209, 256, 1'b1, 0, BG, 1'b0);
    expect_at("r31c0_addr", 1, AD0, 12'd31);
    probe("r31c0", 208, 255, 1'b1, 0, FG, 1'b1);
    probe("r31c223", 431, 255, 1'b1, 0, FG, 1'b1);
    expect_at("blank_rgb", 2, RGB0, 12'h000);
    pix(209, 224, 1'b0);

    probe("s2_c1a", 210, 224, 1'b1, 1, FG, 1'b1);
    expect_at("s2_c1b_addr", 1, AD1, 12'd0);
    probe("s2_c1b", 211, 225, 1'b1, 1, FG, 1'b1);
    probe("s2_c0", 209, 224, 1'b1, 1, BG, 1'b0);
    expect_at("s2_last_addr", 1, AD1, 12'd31);
    probe("s2_last", 655, 287, 1'b1, 1, FG, 1'b1);
    probe("s2_right_out", 656, 224, 1'b1, 1, BG, 1'b0);

    blink_en = 1'b1;
    tick();
    probe("blink_on2", 209, 224, 1'b1, 0, FG, 1'b1);
    tick();
    probe("blink_hide1", 209, 224, 1'b1, 0, BG, 1'b0);
    probe("ring_left", 206, 224, 1'b1, 0, RING_LIVE, 1'b0);
    probe("ring_corner", 433, 257, 1'b1, 0, RING_LIVE, 1'b0);
    probe("ring_outside", 205, 224, 1'b1, 0, BG, 1'b0);
    tick();
    probe("blink_hide2", 209, 224, 1'b1, 0, BG, 1'b0);
    tick();
    probe("blink_on3", 209, 224, 1'b1, 0, FG, 1'b1);

    text_en = 1'b0;
    probe("mid_frame_hold", 209, 224, 1'b1, 0, FG, 1'b1);
    tick();
    probe("disabled", 209, 224, 1'b1, 0, BG, 1'b0);
    blink_en = 1'b0;

    text_en = 1'b1;
    tick();
    repeat (3) pix(0, 0, 1'b0);
    hsync_in = 1'b0;
    pix(209, 224, 1'b1);
    pix(209, 224, 1'b1);
    pix(209, 224, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_rgb", {20'd0, rgb0}, 32'd0);
    check_eq("midrst_tp", {31'd0, tp0}, 32'd0);
    check_eq("midrst_hs", {31'd0, hs0}, 32'd1);
    sb.delete();
    hsync_in = 1'b1;
    step();
    rst_n = 1'b1;
    probe("post_rst_off", 209, 224, 1'b1, 0, BG, 1'b0);
    tick();
    probe("post_rst_on", 209, 224, 1'b1, 0, FG, 1'b1);

    repeat (4) pix(0, 0, 1'b0);
    check_eq("sb_drain", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
